// File: rtl/wb_hyperram_arbiter.sv
// wb_hyperram_arbiter
// Two-master Wishbone classic arbiter in front of the single HyperRAM slave.
// Master 0 is the management bus, master 1 a user-side master (e.g. DMA).
// Round-robin grant, held for the whole cyc so bursts are never split.
// Optional build macro: ARB_TIMEOUT_EN adds a watchdog that ends stalled
// cycles with a one-cycle err pulse to the owner.
//
// Handshake: a master requests with cyc & stb. The owner's signals go
// straight to the slave, and a transfer completes in the cycle the slave
// raises ack. A master that is not the owner never has its stb forwarded
// and never sees ack, err or read data; it simply waits.

module wb_hyperram_arbiter #(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  // master 0
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  input  logic            m0_we_i,
  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW-1:0]   m0_dat_i,
  input  logic [DW/8-1:0] m0_sel_i,
  output logic [DW-1:0]   m0_dat_o,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  // master 1
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  input  logic            m1_we_i,
  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW-1:0]   m1_dat_i,
  input  logic [DW/8-1:0] m1_sel_i,
  output logic [DW-1:0]   m1_dat_o,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  // slave
  output logic            s_cyc_o,
  output logic            s_stb_o,
  output logic            s_we_o,
  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  output logic [DW/8-1:0] s_sel_o,
  input  logic [DW-1:0]   s_dat_i,
  input  logic            s_ack_i,
  // observation: one-hot owner, doubles as the visible FSM state
  output logic [1:0]      grant_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_GNT0 = 2'd1;
  localparam logic [1:0] ST_GNT1 = 2'd2;

  logic [1:0] state, state_next;
  logic       last, last_next;   // master granted most recently (1 = m1)
  logic       req0, req1;
  logic       timeout;           // watchdog expiry in this cycle
  logic [1:0] blocked;           // master timed out and has not yet dropped cyc

`ifdef ARB_TIMEOUT_EN
  logic [15:0] wait_cnt;
  logic        owner_stb;

  assign owner_stb = ((state == ST_GNT0) && m0_stb_i) ||
                     ((state == ST_GNT1) && m1_stb_i);
  assign timeout   = ((state == ST_GNT0) || (state == ST_GNT1)) &&
                     (wait_cnt == 16'(TIMEOUT_CYCLES));

  // Count owner stall cycles; any ack or change of owner restarts the count.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i)
      wait_cnt <= '0;
    else if (s_ack_i || (state_next != state))
      wait_cnt <= '0;
    else if (owner_stb)
      wait_cnt <= wait_cnt + 16'd1;
  end

  // A timed-out master stays out of arbitration until its cyc has been low.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      blocked <= 2'b00;
    end else begin
      if (!m0_cyc_i)
        blocked[0] <= 1'b0;
      else if (timeout && (state == ST_GNT0))
        blocked[0] <= 1'b1;
      if (!m1_cyc_i)
        blocked[1] <= 1'b0;
      else if (timeout && (state == ST_GNT1))
        blocked[1] <= 1'b1;
    end
  end
`else
  // No watchdog: never expires for any legal (non-zero) limit.
  assign timeout = (TIMEOUT_CYCLES == 0);
  assign blocked = 2'b00;
`endif

  assign req0 = m0_cyc_i && m0_stb_i && !blocked[0];
  assign req1 = m1_cyc_i && m1_stb_i && !blocked[1];

  // Round-robin next-state: hold the grant for the whole cyc of the owner.
  always_comb begin
    state_next = state;
    last_next  = last;
    case (state)
      ST_IDLE: begin
        if (req0 && req1) begin
          if (last) begin
            state_next = ST_GNT0;
            last_next  = 1'b0;
          end else begin
            state_next = ST_GNT1;
            last_next  = 1'b1;
          end
        end else if (req0) begin
          state_next = ST_GNT0;
          last_next  = 1'b0;
        end else if (req1) begin
          state_next = ST_GNT1;
          last_next  = 1'b1;
        end
      end
      ST_GNT0: begin
        if (timeout) begin
          state_next = ST_IDLE;
        end else if (!m0_cyc_i) begin
          if (req1) begin
            state_next = ST_GNT1;
            last_next  = 1'b1;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      ST_GNT1: begin
        if (timeout) begin
          state_next = ST_IDLE;
        end else if (!m1_cyc_i) begin
          if (req0) begin
            state_next = ST_GNT0;
            last_next  = 1'b0;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State register; last starts at m1 so m0 wins the first tie.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= ST_IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_next;
      last  <= last_next;
    end
  end

  // Owner mux toward the slave and return path back to the owner only.
  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_adr_o  = '0;
    s_dat_o  = '0;
    s_sel_o  = '0;
    m0_dat_o = '0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_dat_o = '0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    grant_o  = 2'b00;
    case (state)
      ST_GNT0: begin
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_stb_i && !timeout;
        s_we_o   = m0_we_i;
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        s_sel_o  = m0_sel_i;
        m0_dat_o = s_dat_i;
        m0_ack_o = s_ack_i;
        m0_err_o = timeout;
        grant_o  = 2'b01;
      end
      ST_GNT1: begin
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_stb_i && !timeout;
        s_we_o   = m1_we_i;
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        s_sel_o  = m1_sel_i;
        m1_dat_o = s_dat_i;
        m1_ack_o = s_ack_i;
        m1_err_o = timeout;
        grant_o  = 2'b10;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/wb_hyperram_arbiter.md
# wb_hyperram_arbiter

Two-master Wishbone (classic, B4) arbiter that shares the single HyperRAM Wishbone slave (`wrapped_wb_hyperram`) between the Caravel management bus (master 0) and a second user-side master (master 1, e.g. a DMA engine). It sits inside `user_project_wrapper`, between the masters and the slave port. It grants the slave to one master at a time using round-robin, and holds the grant for the whole `cyc` cycle so bursts are never split. An optional watchdog terminates stalled cycles with an error.

## Interface
Parameters:
- `AW`, 32, address width.
- `DW`, 32, data width; `sel` width is `DW/8`.
- `TIMEOUT_CYCLES`, 255, watchdog limit in cycles (1..65535); used only with `ARB_TIMEOUT_EN`.

Ports (`mN` = `m0` / `m1`):
- `wb_clk_i`  in  1  single clock for all logic.
- `wb_rst_i`  in  1  synchronous, active-high reset.
- `mN_cyc_i`, `mN_stb_i`, `mN_we_i`  in  1 each  master N bus-cycle, strobe and write-enable.
- `mN_adr_i`  in  AW  master N address.
- `mN_dat_i`  in  DW  master N write data.
- `mN_sel_i`  in  DW/8  master N byte selects.
- `mN_dat_o`  out  DW  read data to master N.
- `mN_ack_o`  out  1  acknowledge to master N.
- `mN_err_o`  out  1  error to master N.
- `s_cyc_o`, `s_stb_o`, `s_we_o`  out  1 each  to the slave.
- `s_adr_o`  out  AW  to the slave.
- `s_dat_o`  out  DW  to the slave.
- `s_sel_o`  out  DW/8  to the slave.
- `s_dat_i`  in  DW  slave read data.
- `s_ack_i`  in  1  slave acknowledge.
- `grant_o`  out  2  one-hot current owner (bit0 = m0); observation only.

## Operation
- FSM states: IDLE, GNT0, GNT1. A request from master N is `mN_cyc_i & mN_stb_i`.
- Reset:
  - state = IDLE and `last` = 1, so m0 wins the first tie.
  - Outputs: `grant_o` = 0, `s_cyc_o` = 0, `s_stb_o` = 0, all `mN_ack_o` = 0, all `mN_err_o` = 0, `mN_dat_o` = 0, watchdog count = 0.
- Transitions from IDLE:
  - If only one master requests, that master is granted.
  - If both request, the master ≠ `last` is granted.
  - `last` updates to the master being granted.
- Transitions from GNTn:
  - Stay while `mn_cyc_i` = 1, whatever the other master does.
  - When `mn_cyc_i` = 0: go to GNTother if the other master is requesting in that cycle (`last` updated), else go to IDLE.
- Datapath:
  - `s_cyc_o` = `mn_cyc_i` only in GNTn, else 0.
  - `s_stb_o`, `s_we_o`, `s_adr_o`, `s_dat_o`, `s_sel_o` are muxed combinationally from the owner.
  - In IDLE: `s_stb_o` = 0 and the other slave-side outputs are 0.
- Return path:
  - `mn_ack_o` = `s_ack_i` only when master n is the owner. A non-owner always sees ack = 0.
  - `mn_dat_o` = `s_dat_i` when master n is the owner, else 0.
- A non-granted master simply waits. Its strobe is never forwarded and never acknowledged.
- Mid-cycle reset: state returns to IDLE and `s_cyc_o` drops in the cycle after reset is sampled. No ack is forwarded after that point.

## Timing
- Arbitration latency is 1 cycle:
  - A request sampled at edge k gives state GNTn after edge k.
  - `s_cyc_o`/`s_stb_o` are visible in cycle k+1.
  - No ack can reach the master before cycle k+1.
- The ack path is combinational (0 cycles added). Pipelined slave acks pass through unchanged.
- Handover: the owner drops `cyc` in cycle j. The other master is driven onto the slave in cycle j+1. No dead cycle is inserted beyond the 1-cycle arbitration.
- With both masters continuously re-requesting, ownership alternates m0, m1, m0, …

## Configuration
`ARB_TIMEOUT_EN`:
- Defined:
  - A 16-bit counter increments each cycle that the owner has `stb` = 1 and `s_ack_i` = 0. It clears on an ack, on leaving GNTn, and on reset.
  - When the count reaches `TIMEOUT_CYCLES`, the owner's `mN_err_o` pulses for exactly 1 cycle and `s_stb_o` is forced to 0 in that cycle.
  - The state then goes to IDLE. The owner must drop `cyc` before it is considered again; a still-asserted stale `cyc` does not re-grant until it has been low for ≥1 cycle.
- Undefined: the counter is not built and `mN_err_o` are tied to 0.

## Test plan
- Single master: after reset, m0 reads `adr` 0x10 and the slave acks in cycle 3 with data 0xDEADBEEF. Required: `grant_o` = 01 in cycle 1, `m0_dat_o` = 0xDEADBEEF with `m0_ack_o` = 1 in cycle 3, `m1_ack_o` = 0 throughout.
- Tie: m0 and m1 both request in the same cycle after reset. Required: m0 granted first; on m0's `cyc` fall, `grant_o` = 10 in the next cycle; m1's `adr` appears on `s_adr_o`.
- Burst hold: m1 holds `cyc` for 4 back-to-back writes (acks every cycle) while m0 requests. Required: 4 acks to m1 only, m0 untouched until m1's `cyc` drops, then `grant_o` = 01.
- Fairness: both masters re-request continuously for 6 single transfers. Required grant sequence: m0, m1, m0, m1, m0, m1.
- Reset mid-cycle: assert `wb_rst_i` while GNT0 waits on an ack. Required: `s_cyc_o` = 0 and `grant_o` = 0 the next cycle, and a later `s_ack_i` = 1 is not forwarded.
- Timeout (with `ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES` = 8): the slave never acks m0. Required: `m0_err_o` = 1 for exactly one cycle after 8 stalled cycles, then state IDLE; a pending m1 request is granted next.
